// File: rtl/regfile_clr.sv
// Two-read/one-write register file with registered reads, write-first forwarding,
// optional hardwired-zero entry 0 and a one-entry-per-cycle clear sweep.
module regfile_clr #(
  parameter int WIDTH    = 32,
  parameter int AWIDTH   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WrEn,
  input  logic [AWIDTH-1:0] Aw,
  input  logic [WIDTH-1:0]  Dw,
  input  logic [AWIDTH-1:0] Aa,
  input  logic [AWIDTH-1:0] Ab,
  output logic [WIDTH-1:0]  Da,
  output logic [WIDTH-1:0]  Db,
  input  logic              clr,
  output logic              busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [AWIDTH-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic             wr_acc;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  always_comb begin
    wr_acc = WrEn && !busy && !((ZERO_REG != 0) && (Aw == '0));
  end

  // Forwarding uses the same accept qualifier as the write, so discarded
  // writes (busy or entry 0) are never forwarded.
  always_comb begin
    rd_a = mem[Aa];
    if ((ZERO_REG != 0) && (Aa == '0))
      rd_a = '0;
    else if (wr_acc && (Aw == Aa))
      rd_a = Dw;
  end

  always_comb begin
    rd_b = mem[Ab];
    if ((ZERO_REG != 0) && (Ab == '0))
      rd_b = '0;
    else if (wr_acc && (Aw == Ab))
      rd_b = Dw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      Da       <= '0;
      Db       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      clr_done <= 1'b0;
      Da       <= busy ? '0 : rd_a;
      Db       <= busy ? '0 : rd_b;
      case (state)
        IDLE: begin
          if (wr_acc)
            mem[Aw] <= Dw;
          if (clr) begin
            state <= SWEEP;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          mem[ptr] <= '0;
          // Compare before incrementing so the pointer never wraps.
          if (ptr == AWIDTH'(DEPTH - 1)) begin
            state    <= IDLE;
            ptr      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_clr.sv
// Directed self-checking bench for regfile_clr: reads, forwarding, zero entry,
// clear sweep timing, clr during sweep and asynchronous reset mid-sweep.
module tb_regfile_clr;

  logic        clk;
  logic        rst_n;
  logic        WrEn;
  logic [4:0]  Aw;
  logic [31:0] Dw;
  logic [4:0]  Aa;
  logic [4:0]  Ab;
  logic [31:0] Da;
  logic [31:0] Db;
  logic        clr;
  logic        busy;
  logic        clr_done;

  int n_cmp;
  int n_err;
  int cnt;
  int done_cnt;

  regfile_clr #(.WIDTH(32), .AWIDTH(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .WrEn(WrEn), .Aw(Aw), .Dw(Dw),
    .Aa(Aa), .Ab(Ab), .Da(Da), .Db(Db),
    .clr(clr), .busy(busy), .clr_done(clr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b1; WrEn = 1'b0; Aw = '0; Dw = '0; Aa = '0; Ab = '0; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_Da", Da, 32'h0);
    chk("rst_Db", Db, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, clr_done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain write then registered read
    WrEn = 1'b1; Aw = 5'd5; Dw = 32'hDEADBEEF;
    step();
    WrEn = 1'b0; Aa = 5'd5; Ab = 5'd0;
    step();
    chk("rd_a5", Da, 32'hDEADBEEF);
    chk("rd_b0", Db, 32'h0);

    // Write-first forwarding on both ports
    WrEn = 1'b1; Aw = 5'd7; Dw = 32'h12345678; Aa = 5'd7; Ab = 5'd7;
    step();
    chk("fwd_a7", Da, 32'h12345678);
    chk("fwd_b7", Db, 32'h12345678);
    WrEn = 1'b0;
    step();
    chk("mem_a7", Da, 32'h12345678);

    // Forward on B only, A reads stored value
    WrEn = 1'b1; Aw = 5'd9; Dw = 32'hA5A5A5A5; Aa = 5'd5; Ab = 5'd9;
    step();
    chk("nofwd_a5", Da, 32'hDEADBEEF);
    chk("fwd_b9", Db, 32'hA5A5A5A5);

    // Entry 0 hardwired to zero, including the forwarding path
    WrEn = 1'b1; Aw = 5'd0; Dw = 32'hFFFFFFFF; Aa = 5'd0; Ab = 5'd5;
    step();
    chk("z0_fwd_a", Da, 32'h0);
    chk("z0_b5", Db, 32'hDEADBEEF);
    WrEn = 1'b0;
    step();
    chk("z0_mem_a", Da, 32'h0);

    // Fill every entry with addr+1
    for (int i = 0; i < 32; i++) begin
      WrEn = 1'b1; Aw = 5'(i); Dw = 32'(i + 1);
      step();
    end
    WrEn = 1'b0; Aa = 5'd31; Ab = 5'd1;
    step();
    chk("fill_a31", Da, 32'd32);
    chk("fill_b1", Db, 32'd2);

    // Clear sweep; write on the clr edge is accepted then swept away
    clr = 1'b1; WrEn = 1'b1; Aw = 5'd4; Dw = 32'h44; Aa = 5'd3; Ab = 5'd4;
    step();
    chk("clr_busy", {31'b0, busy}, 32'h1);
    chk("clr_edge_a3", Da, 32'd4);
    chk("clr_edge_fwd_b4", Db, 32'h44);
    clr = 1'b0; WrEn = 1'b1; Aw = 5'd2; Dw = 32'hBAD0BAD0; Aa = 5'd31; Ab = 5'd30;
    cnt = 1;
    step();
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      cnt++;
      chk("sweep_Da", Da, 32'h0);
      chk("sweep_done", {31'b0, clr_done}, 32'h0);
      step();
    end
    WrEn = 1'b0;
    chk("sweep_len", 32'(cnt), 32'd32);
    chk("sweep_done_pulse", {31'b0, clr_done}, 32'h1);
    chk("sweep_end_Da", Da, 32'h0);
    step();
    chk("done_one_cycle", {31'b0, clr_done}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      Aa = 5'(i); Ab = 5'(31 - i);
      step();
      chk("clr_rd_a", Da, 32'h0);
      chk("clr_rd_b", Db, 32'h0);
    end

    // clr re-asserted mid-sweep neither restarts nor extends it
    WrEn = 1'b1; Aw = 5'd6; Dw = 32'h66;
    step();
    WrEn = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; cnt = 0; done_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      cnt++;
      if (clr_done) done_cnt++;
      clr = (cnt >= 10 && cnt < 20);
      step();
    end
    clr = 1'b0;
    chk("reclr_len", 32'(cnt), 32'd32);
    for (int k = 0; k < 4; k++) begin
      if (clr_done) done_cnt++;
      chk("reclr_idle", {31'b0, busy}, 32'h0);
      step();
    end
    chk("reclr_done_cnt", 32'(done_cnt), 32'd1);
    Aa = 5'd6;
    step();
    chk("reclr_a6", Da, 32'h0);

    // Asynchronous reset between edges while idle clears read data at once
    WrEn = 1'b1; Aw = 5'd8; Dw = 32'h88; Aa = 5'd8; Ab = 5'd8;
    step();
    WrEn = 1'b0;
    chk("pre_rst_a8", Da, 32'h88);
    #2 rst_n = 1'b0;
    #1;
    chk("idle_rst_Da", Da, 32'h0);
    chk("idle_rst_Db", Db, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_rst_mem8", Da, 32'h0);

    // Asynchronous reset mid-sweep
    WrEn = 1'b1; Aw = 5'd20; Dw = 32'h20;
    step();
    WrEn = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("mid_busy", {31'b0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_done", {31'b0, clr_done}, 32'h0);
    chk("mid_rst_Da", Da, 32'h0);
    chk("mid_rst_Db", Db, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; Aa = 5'd20; Ab = 5'd31;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_busy", {31'b0, busy}, 32'h0);
      chk("post_rst_done", {31'b0, clr_done}, 32'h0);
    end
    chk("post_rst_a20", Da, 32'h0);
    chk("post_rst_b31", Db, 32'h0);

    // Normal operation resumes
    WrEn = 1'b1; Aw = 5'd3; Dw = 32'h33; Aa = 5'd3; Ab = 5'd0;
    step();
    WrEn = 1'b0;
    step();
    chk("resume_a3", Da, 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
